// File: rtl/gate_check_pkg.sv
// Shared types and helpers for the gate sweep checker.
// Holds the FSM state type and the expected-response model.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } gc_state_t;

  localparam int unsigned GC_VEC_COUNT = 4;
  localparam int unsigned GC_Z_W = 2;

  function automatic logic [GC_Z_W:1] gc_expected(
    input logic a,
    input logic b
  );
    return {1'b0, a & b};
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle timer: counts 0..SETTLE_CYCLES while enabled.
// Flags expire on the terminal count, then wraps to 0.
module gate_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);

  logic [3:0] cnt;

  assign expire = (cnt == 4'(SETTLE_CYCLES));

  // count up, wrap on expire, hold at 0 while restart is high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps {x,y} through a two-input gate and checks z.
// GATE_STOP_ON_ERR_EN: end the run on the first mismatch.
module gate_sweep_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             x,
  output logic             y,
  input  logic [GC_Z_W:1]  z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [1:0]       first_err_vec
);

  gc_state_t state;
  gc_state_t state_nxt;
  logic [1:0] vec;
  logic [7:0] pass_cnt;
  logic [7:0] err_nxt;
  logic expire;
  logic sample;
  logic mismatch;
  logic last_vec;
  logic last_pass;
  logic finish;

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .restart(state != DRIVE),
    .expire(expire)
  );

  assign sample = (state == DRIVE) && expire;
  assign mismatch = sample && (z != gc_expected(x, y));
  assign last_vec = (vec == 2'(GC_VEC_COUNT - 1));
  assign last_pass = (pass_cnt == 8'(PASSES - 1));

`ifdef GATE_STOP_ON_ERR_EN
  assign finish = sample && ((last_vec && last_pass) || mismatch);
`else
  assign finish = sample && last_vec && last_pass;
`endif

  assign err_nxt = (mismatch && err_count != 8'hff)
                 ? err_count + 8'd1 : err_count;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // vector sequencing, error tally and verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= 1'b0;
      y <= 1'b0;
      vec <= '0;
      pass_cnt <= '0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_vec <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            x <= 1'b0;
            y <= 1'b0;
            vec <= '0;
            pass_cnt <= '0;
            pass <= 1'b0;
            err_count <= '0;
            first_err_vec <= '0;
          end
        end
        DRIVE: begin
          err_count <= err_nxt;
          if (mismatch && err_count == 8'd0) begin
            first_err_vec <= vec;
          end
          if (finish) begin
            x <= 1'b0;
            y <= 1'b0;
            pass <= (err_nxt == 8'd0);
          end else if (sample && !last_vec) begin
            vec <= vec + 2'd1;
            {x, y} <= vec + 2'd1;
          end else if (sample) begin
            vec <= '0;
            {x, y} <= 2'b00;
            pass_cnt <= pass_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker.
// Three instances cover settle/pass/saturation corners.
module tb_gate_sweep_checker;

  typedef struct {
    int id;
    int err;
    int fev;
    int pass;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_w [3];
  logic x_w [3];
  logic y_w [3];
  logic [2:1] z_w [3];
  logic busy_w [3];
  logic done_w [3];
  logic pass_w [3];
  logic [7:0] err_w [3];
  logic [1:0] fev_w [3];
  int fault [3];

  exp_t q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // gate model with injectable faults
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      z_w[i] = {1'b0, x_w[i] & y_w[i]};
      case (fault[i])
        1: z_w[i] = 2'b01;
        2: z_w[i] = {1'b1, x_w[i] & y_w[i]};
        3: z_w[i] = 2'b00;
        default: z_w[i] = {1'b0, x_w[i] & y_w[i]};
      endcase
    end
  end

  gate_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_w[0]),
    .x(x_w[0]), .y(y_w[0]), .z(z_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .first_err_vec(fev_w[0])
  );

  gate_sweep_checker #(.SETTLE_CYCLES(0), .PASSES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_w[1]),
    .x(x_w[1]), .y(y_w[1]), .z(z_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .first_err_vec(fev_w[1])
  );

  gate_sweep_checker #(.SETTLE_CYCLES(0), .PASSES(255)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_w[2]),
    .x(x_w[2]), .y(y_w[2]), .z(z_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err_w[2]), .first_err_vec(fev_w[2])
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", i, -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_id", i, e.id);
          chk("done_cycle", cyc, e.cyc);
          chk("err_count", int'(err_w[i]), e.err);
          chk("first_err_vec", int'(fev_w[i]), e.fev);
          chk("pass", int'(pass_w[i]), e.pass);
        end
      end
    end
  end

  task automatic chk_zero(input int i);
    chk("rst_x", int'(x_w[i]), 0);
    chk("rst_y", int'(y_w[i]), 0);
    chk("rst_busy", int'(busy_w[i]), 0);
    chk("rst_done", int'(done_w[i]), 0);
    chk("rst_pass", int'(pass_w[i]), 0);
    chk("rst_err", int'(err_w[i]), 0);
    chk("rst_fev", int'(fev_w[i]), 0);
  endtask

  task automatic run(input int id, input int flt, input int e_err,
                     input int e_fev, input int e_pass, input int lat,
                     input bit trace);
    exp_t e;
    fault[id] = flt;
    @(negedge clk);
    #1;
    e.id = id;
    e.err = e_err;
    e.fev = e_fev;
    e.pass = e_pass;
    e.cyc = cyc + 1 + lat;
    q.push_back(e);
    start_w[id] = 1'b1;
    for (int k = 1; k <= lat + 4 && q.size() != 0; k++) begin
      @(negedge clk);
      #1;
      start_w[id] = 1'b0;
      if (trace && k <= 12) begin
        chk("trace_xy", int'({x_w[id], y_w[id]}), (k - 1) / 3);
        chk("trace_busy", int'(busy_w[id]), 1);
      end
    end
    start_w[id] = 1'b0;
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      fault[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i);
    rst = 1'b0;
    @(negedge clk);

    run(0, 0, 0, 0, 1, 12, 1'b1);
    chk("idle_after_run", int'(busy_w[0]), 0);
`ifdef GATE_STOP_ON_ERR_EN
    run(0, 1, 1, 0, 0, 3, 1'b0);
    run(0, 3, 1, 3, 0, 12, 1'b0);
    run(1, 2, 1, 0, 0, 1, 1'b0);
    run(1, 1, 1, 0, 0, 1, 1'b0);
    run(2, 2, 1, 0, 0, 1, 1'b0);
`else
    run(0, 1, 3, 0, 0, 12, 1'b0);
    run(0, 3, 1, 3, 0, 12, 1'b0);
    run(1, 2, 8, 0, 0, 8, 1'b0);
    run(1, 1, 6, 0, 0, 8, 1'b0);
    run(2, 2, 255, 0, 0, 1020, 1'b0);
`endif
    run(1, 0, 0, 0, 1, 8, 1'b0);
    run(0, 0, 0, 0, 1, 12, 1'b0);

    // start re-pulsed at cycles 3 and 13 is ignored
    begin
      exp_t e;
      fault[0] = 0;
      #1;
      e.id = 0;
      e.err = 0;
      e.fev = 0;
      e.pass = 1;
      e.cyc = cyc + 13;
      q.push_back(e);
      start_w[0] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        #1;
        start_w[0] = (k == 3 || k == 13);
      end
      start_w[0] = 1'b0;
      chk("repulse_pending", q.size(), 0);
      chk("repulse_busy", int'(busy_w[0]), 0);
      q.delete();
    end

    // reset mid-run aborts without a done pulse
    @(negedge clk);
    #1;
    start_w[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      start_w[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk_zero(0);
    repeat (20) @(negedge clk);
    run(0, 0, 0, 0, 1, 12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus-and-check engine: the driving end for the small two-input gate modules in this codebase, such as the AND gate with a 2-bit `z[2:1]` output. On `start`, it sweeps all four `{x,y}` input combinations through the gate under test. For each vector it waits a programmable settle time, samples `z`, and compares it against the expected response `{1'b0, x&y}`. It reports pass/fail, an error count and the first failing vector. It sits in the bench/self-test wrapper beside the gate instance.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between driving a vector and sampling `z`; legal range 0..15.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: run request; accepted only in IDLE.
- `x` out 1: gate input A.
- `y` out 1: gate input B.
- `z` in 2 (`[2:1]`): gate response.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse at end of run.
- `pass` out 1: high when the last completed run had zero errors; held until next `start`.
- `err_count` out 8: mismatches in the current/last run; saturates at 255.
- `first_err_vec` out 2: `{x,y}` of the first mismatch in the run; 0 if none.

## Operation
- Reset: state=IDLE. Outputs `x`, `y`, `busy`, `done`, `pass`, `err_count` and `first_err_vec` all reset to 0. The `vec`, `pass_cnt` and settle counters also reset to 0.
- FSM states: IDLE, DRIVE, DONE.
- IDLE with `start`=1:
  - clear `err_count`, `first_err_vec` and `pass`
  - `vec`=0, `pass_cnt`=0
  - go to DRIVE
- DRIVE:
  - `{x,y}`=`vec` (registered).
  - Settle counter runs 0..`SETTLE_CYCLES`.
  - On the cycle the counter equals `SETTLE_CYCLES`, `z` is sampled and compared with expected `{1'b0, x&y}`: `z[2]` must be 0 and `z[1]` must equal `x&y`.
- On mismatch:
  - `err_count` increments (saturating at 255).
  - If this is the first error of the run, `first_err_vec`=`vec`.
- After the sample:
  - If `vec`<3: `vec`+1 and restart the settle count.
  - Else if `pass_cnt`<`PASSES`-1: `vec`=0 and `pass_cnt`+1.
  - Else: go to DONE.
- DONE (one cycle):
  - `done`=1
  - `pass` = (`err_count`==0), evaluated including any error found on the final sample
  - `{x,y}` return to 0
  - next state IDLE
- `start` in DRIVE or DONE is ignored; there is no queuing.
- `rst` mid-run aborts the run immediately to reset values; no `done` pulse is produced.
- `SETTLE_CYCLES`=0: `z` is sampled in the same cycle the vector is driven, so the gate path must be combinational within one cycle.

## Timing
- `start` sampled high at edge T:
  - DRIVE occupies T+1 .. T+4·(`SETTLE_CYCLES`+1)·`PASSES`.
  - `done`/DONE occupy the following cycle.
  - IDLE resumes the cycle after that.
- Each vector is held for exactly `SETTLE_CYCLES`+1 cycles; `x`/`y` change only on vector boundaries.
- `err_count` updates the cycle after its sample.

## Configuration
- `GATE_STOP_ON_ERR_EN` defined: the first mismatch moves the FSM straight from DRIVE to DONE at the next edge, with `pass`=0 and `err_count`=1.
- Macro undefined: the full sweep always completes and all mismatches are counted.

## Structure
- Package `gate_check_pkg`:
  - state enum typedef `gc_state_t` {IDLE, DRIVE, DONE}
  - constant `GC_VEC_COUNT`=4
  - constant `GC_Z_W`=2
  - function `gc_expected(x,y)` returning `{1'b0, x&y}`
- One sub-module: `gate_settle_timer`. Parameter `SETTLE_CYCLES`; inputs `clk`, `rst`, `restart`; output `expire`, asserted on count==`SETTLE_CYCLES`.

## Test plan
- Correct AND model, `SETTLE_CYCLES`=2, `PASSES`=1, `start` at cycle 0:
  - vectors 00, 01, 10, 11 each held 3 cycles (cycles 1..12)
  - `done` at cycle 13, `pass`=1, `err_count`=0, `first_err_vec`=0
- `z[1]` stuck at 1: `err_count`=3 (vectors 00, 01, 10), `first_err_vec`=00, `pass`=0.
- `z[2]` stuck at 1 with `PASSES`=2: `err_count`=8, `first_err_vec`=00.
- `start` re-pulsed at cycles 3 and 13: ignored; exactly one `done`, at cycle 13.
- `rst` at cycle 6 mid-run:
  - next cycle all outputs are 0 and state is IDLE
  - no `done` pulse
  - new `start` runs cleanly to `pass`=1
- With `GATE_STOP_ON_ERR_EN` and `z[1]` stuck at 1, `SETTLE_CYCLES`=0: mismatch at cycle 1, `done` at cycle 2, `err_count`=1, `first_err_vec`=00.
